// File: rtl/mbit_sel_pkg.sv
// mbit_sel_pkg
//   Shared types and helpers for the two-source select arbiter.
//   - state_t : arbiter FSM states
//   - src_t   : identity of the source that most recently held the grant
//   - WORD_W  : width of the selected output word
//   - pack_a  : builds the 130-bit word presented by source A
package mbit_sel_pkg;

  localparam int WORD_W = 130;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  // Source A has no bit 128 of its own; its 64-bit payload fills both halves.
  function automatic logic [WORD_W-1:0] pack_a(input logic d, input logic [63:0] e);
    return {d, 1'b0, e, e};
  endfunction

endpackage

// File: rtl/mbit_sel_outreg.sv
// mbit_sel_outreg
//   Single-entry valid/ready output register holding the selected word and
//   its mux controls.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     load_i          a source word is granted this cycle
//     ready_i         downstream accepts data_o this cycle
//     sel_b_i         sel_b value belonging to the word being loaded
//     data_i          word being loaded
//     valid_o         data_o holds an unconsumed word
//     sel_b_o,sel_c_o registered mux controls
//     data_o          registered word
module mbit_sel_outreg
  import mbit_sel_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic              sel_b_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              valid_o,
  output logic              sel_b_o,
  output logic              sel_c_o,
  output logic [WORD_W-1:0] data_o
);

  logic              valid_q;
  logic              sel_b_q;
  logic              sel_c_q;
  logic [WORD_W-1:0] data_q;

  // A load always wins over a drain: the upstream grant is only issued when
  // the slot is empty or being consumed in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      sel_b_q <= 1'b0;
      sel_c_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      sel_b_q <= sel_b_i;
      sel_c_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_q && ready_i) begin
      // Drained with nothing new: mux goes idle, data and sel_b are kept.
      valid_q <= 1'b0;
      sel_c_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign sel_b_o = sel_b_q;
  assign sel_c_o = sel_c_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mbit_sel_arb.sv
// mbit_sel_arb
//   Round-robin arbiter/sequencer for the 130-bit two-source select datapath.
//   Grants source A or B with bounded bursts and registers the chosen word
//   into a single-entry valid/ready output stage.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     a_req, a_d, a_e, a_gnt     source A request, fields, consume strobe
//     b_req, b_f, b_g, b_e, b_gnt source B request, fields, consume strobe
//     sel_b, sel_c               registered mux controls (1x = selected, b=1 A path)
//     out_valid, out_ready       output handshake
//     out_data                   registered selected word
module mbit_sel_arb
  import mbit_sel_pkg::*;
#(
  parameter  int MAX_BURST = 4,
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_d,
  input  logic [63:0]       a_e,
  output logic              a_gnt,
  input  logic              b_req,
  input  logic              b_f,
  input  logic              b_g,
  input  logic [127:0]      b_e,
  output logic              b_gnt,
  output logic              sel_b,
  output logic              sel_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  src_t             last_q, last_d;
  logic             load_en;
  logic             own_req, oth_req;
  logic [WORD_W-1:0] word_sel;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SRC_B;   // so A wins the first tie
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_req = 1'b0;
    oth_req = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (a_req && b_req)  state_d = (last_q == SRC_B) ? GNT_A : GNT_B;
        else if (a_req)      state_d = GNT_A;
        else if (b_req)      state_d = GNT_B;
      end
      GNT_A, GNT_B: begin
        own_req = (state_q == GNT_A) ? a_req : b_req;
        oth_req = (state_q == GNT_A) ? b_req : a_req;
        if (!own_req || ((a_gnt || b_gnt) && cnt_q == LAST_CNT)) begin
          // Burst over: hand over if the other side waits, otherwise an
          // uncontested source just restarts its count without a bubble.
          cnt_d  = '0;
          last_d = (state_q == GNT_A) ? SRC_A : SRC_B;
          if (oth_req)      state_d = (state_q == GNT_A) ? GNT_B : GNT_A;
          else if (own_req) state_d = state_q;
          else              state_d = IDLE;
        end else if (a_gnt || b_gnt) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: grants are combinational so a dropped request or a stall
  // releases them in the same cycle.
  always_comb begin
    load_en = !out_valid || out_ready;
    a_gnt   = (state_q == GNT_A) && a_req && load_en;
    b_gnt   = (state_q == GNT_B) && b_req && load_en;
  end

  assign word_sel = a_gnt ? pack_a(a_d, a_e) : {b_f, b_g, b_e};

  mbit_sel_outreg u_outreg (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .load_i  (a_gnt || b_gnt),
    .ready_i (out_ready),
    .sel_b_i (a_gnt),
    .data_i  (word_sel),
    .valid_o (out_valid),
    .sel_b_o (sel_b),
    .sel_c_o (sel_c),
    .data_o  (out_data)
  );

endmodule

// File: tb/tb_mbit_sel_arb.sv
module tb_mbit_sel_arb;
  import mbit_sel_pkg::*;

  localparam int MAXB = 4;
  localparam logic [63:0]  A_E = 64'hfedcba9876543210;
  localparam logic [127:0] B_E = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [129:0] A_WORD = {1'b0, 1'b0, 64'hfedcba9876543210, 64'hfedcba9876543210};
  localparam logic [129:0] B_WORD = 130'h2_0123456789abcdeffedcba9876543210;

  logic clk = 1'b0;
  logic rst_n;
  logic a_req, a_d, b_req, b_f, b_g, out_ready;
  logic [63:0] a_e;
  logic [127:0] b_e;
  logic a_gnt, b_gnt, sel_b, sel_c, out_valid;
  logic [129:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mbit_sel_arb #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_d(a_d), .a_e(a_e), .a_gnt(a_gnt),
    .b_req(b_req), .b_f(b_f), .b_g(b_g), .b_e(b_e), .b_gnt(b_gnt),
    .sel_b(sel_b), .sel_c(sel_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic check(input string nm, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = nobody, 1 = A, 2 = B. run = grants given in the current tenure.
  int m_owner, m_run, m_last;
  logic m_valid, m_selb, m_selc;
  logic [129:0] m_data;

  function automatic logic m_may_load();
    return !m_valid || out_ready;
  endfunction
  function automatic logic m_ga();
    return (m_owner == 1) && a_req && m_may_load();
  endfunction
  function automatic logic m_gb();
    return (m_owner == 2) && b_req && m_may_load();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= 0; m_run <= 0; m_last <= 2;
      m_valid <= 1'b0; m_data <= '0; m_selb <= 1'b0; m_selc <= 1'b0;
    end else begin
      logic ga, gb, mine, theirs;
      ga = m_ga();
      gb = m_gb();
      if (ga) begin
        m_data <= {a_d, 1'b0, a_e, a_e}; m_valid <= 1'b1; m_selb <= 1'b1; m_selc <= 1'b1;
      end else if (gb) begin
        m_data <= {b_f, b_g, b_e}; m_valid <= 1'b1; m_selb <= 1'b0; m_selc <= 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0; m_selc <= 1'b0;
      end
      if (m_owner == 0) begin
        m_run <= 0;
        if (a_req && b_req) m_owner <= (m_last == 2) ? 1 : 2;
        else if (a_req)     m_owner <= 1;
        else if (b_req)     m_owner <= 2;
      end else begin
        mine   = (m_owner == 1) ? a_req : b_req;
        theirs = (m_owner == 1) ? b_req : a_req;
        if (!mine || ((ga || gb) && (m_run + 1 >= MAXB))) begin
          m_last <= m_owner;
          m_run  <= 0;
          m_owner <= theirs ? (3 - m_owner) : (mine ? m_owner : 0);
        end else if (ga || gb) begin
          m_run <= m_run + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cmp_a_gnt", a_gnt, m_ga());
      check("cmp_b_gnt", b_gnt, m_gb());
      check("cmp_valid", out_valid, m_valid);
      check("cmp_data", out_data, m_data);
      check("cmp_sel_b", sel_b, m_selb);
      check("cmp_sel_c", sel_c, m_selc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    string pat;
    int na;
    logic [129:0] held;
    logic held_sb;

    rst_n = 1'b0; a_req = 1'b1; a_d = 1'b0; a_e = A_E;
    b_req = 1'b0; b_f = 1'b1; b_g = 1'b0; b_e = B_E; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sel_b", sel_b, 0);
    check("rst_sel_c", sel_c, 0);
    check("rst_a_gnt", a_gnt, 0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("gnt_first_cycle", a_gnt, 0);
    @(negedge clk); check("gnt_second_cycle", a_gnt, 1);

    // A only, across burst boundaries
    na = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_gnt) na++;
    end
    check("a_only_grants", 130'(na), 130'd10);
    check("a_only_data", out_data, A_WORD);
    check("a_only_sel_b", sel_b, 1);
    check("a_only_sel_c", sel_c, 1);

    // B only
    @(posedge clk); #1 a_req = 1'b0; b_req = 1'b1;
    @(negedge clk); check("switch_a_release", a_gnt, 0);
    @(negedge clk); check("b_first_gnt", b_gnt, 1);
    repeat (2) @(negedge clk);
    check("b_only_data", out_data, B_WORD);
    check("b_only_sel_b", sel_b, 0);
    check("b_only_sel_c", sel_c, 1);

    // Drain
    @(posedge clk); #1 b_req = 1'b0;
    @(negedge clk); check("drain_valid_hold", out_valid, 1);
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    check("drain_sel_c", sel_c, 0);
    check("drain_data_hold", out_data, B_WORD);

    // Both requesting
    @(posedge clk); #1 a_req = 1'b1; b_req = 1'b1;
    pat = "";
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_gnt && b_gnt) pat = {pat, "X"};
      else if (a_gnt)     pat = {pat, "A"};
      else if (b_gnt)     pat = {pat, "B"};
      else                pat = {pat, "-"};
    end
    checks++;
    if (pat != "-AAAABBBBA") begin
      errors++;
      $display("FAIL rr_pattern actual=%s expected=-AAAABBBBA", pat);
    end

    // Backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    held = out_data; held_sb = sel_b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_a_gnt", a_gnt, 0);
      check("bp_b_gnt", b_gnt, 0);
      check("bp_data", out_data, held);
      check("bp_sel_b", sel_b, held_sb);
      check("bp_valid", out_valid, 1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); check("bp_release_gnt", a_gnt, 1);

    // Asynchronous reset mid-burst
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_gnt", a_gnt, 0);
    @(posedge clk); #1 rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbit_sel_arb.md
Name: mbit_sel_arb

Overview:
- Round-robin arbiter and sequencer for the 130-bit two-source select datapath.
- Source A supplies the word {a_d, 1'b0, a_e, a_e}; source B supplies {b_f, b_g, b_e}.
- The block grants one source at a time with bounded bursts, drives the sel_b/sel_c mux controls, and registers the selected word into a single-entry valid/ready output stage.

Parameters:
- MAX_BURST, 4, maximum consecutive transfers granted to one source while the other is requesting (must be >= 1).
- CNT_W, $clog2(MAX_BURST+1), burst counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_req  input  1  source A has a word.
- a_d  input  1  source A MSB field.
- a_e  input  64  source A payload (duplicated into bits 127:0).
- a_gnt  output  1  source A word consumed this cycle.
- b_req  input  1  source B has a word.
- b_f  input  1  source B bit 129.
- b_g  input  1  source B bit 128.
- b_e  input  128  source B payload.
- b_gnt  output  1  source B word consumed this cycle.
- sel_b  output  1  mux control b: 1 = A path.
- sel_c  output  1  mux control c: 1 = a source is selected, 0 = idle (zero word).
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  130  registered selected word.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, sel_b=0, sel_c=0, burst_cnt=0, last=B (so A wins the first tie). a_gnt and b_gnt are combinational and evaluate to 0.
- FSM states: IDLE, GNT_A, GNT_B.
- load_en = !out_valid | out_ready.
- a_gnt = (state==GNT_A) & a_req & load_en. b_gnt is analogous. The two grants are never asserted together.
- Transfer: on a grant, at the next edge out_data <= the source word, out_valid <= 1, and sel_b/sel_c <= 11 (A) or 01 (B). Bit 128 is 0 for A.
- If out_ready & out_valid with no grant, out_valid <= 0 and sel_c <= 0. out_data and sel_b hold their values.
- Stall: while out_valid & !out_ready, out_data, sel_b and sel_c hold, and no grant is issued.
- IDLE transitions:
  - Both requesting: go to the source opposite `last`.
  - One requesting: go to that source.
  - Neither: stay in IDLE.
  - burst_cnt <= 0 on entry to any grant state.
- GNT_x: each grant increments burst_cnt. The state is left when either:
  - req_x is low, or
  - a grant occurs with burst_cnt == MAX_BURST-1.
- On leaving GNT_x: go to GNT_other if req_other, else to GNT_x with burst_cnt reset if req_x is still high, else IDLE. `last` <= x.
- A source with no competitor is never starved by the burst limit. It continues at full rate with only the counter reset.
- Latency:
  - Request in IDLE at edge n: grant is possible in the cycle after n.
  - out_valid rises at the following edge.
  - Throughput is 1 word/cycle while out_ready=1.
  - A source switch adds no bubble: the last A grant and the first B grant occur in consecutive cycles.
- A request dropping while granted releases the grant in the same cycle (a_gnt follows a_req) and exits the state at the next edge.
- Reset mid-burst discards the output word and the grant state immediately.

Decomposition:
- Package mbit_sel_pkg holds:
  - state enum (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2);
  - the SRC_A/SRC_B encoding for `last`;
  - localparam WORD_W=130;
  - function pack_a(d,e) returning {d,1'b0,e,e}.
- One sub-module is natural: mbit_sel_outreg, the 130-bit + sel single-entry valid/ready register.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: rst_n=0 with a_req=1 → out_valid=0, out_data=0, sel_b=0, sel_c=0, a_gnt=0. Release rst_n → a_gnt=1 in the second cycle.
- A only: a_d=0, a_e=64'hfedcba9876543210, out_ready=1.
  - out_data = {1'b0,1'b0,64'hfedcba9876543210,64'hfedcba9876543210}.
  - sel_b=1, sel_c=1.
  - Continuous grants, no gap at the burst boundary.
- B only: f=1, g=0, b_e=128'h0123456789abcdeffedcba9876543210 → out_data=130'h2_0123456789abcdeffedcba9876543210, sel_b=0, sel_c=1.
- Both request continuously, MAX_BURST=4, out_ready=1 → grant pattern A,A,A,A,B,B,B,B,A… with no idle cycles.
- Backpressure: out_ready=0 for 3 cycles with a valid word → out_data/sel stable, a_gnt=0. Then out_ready=1 → the next word loads the same cycle.
- Drain: the last request drops and out_ready=1 → out_valid falls and sel_c=0 the next cycle, state=IDLE. An async reset asserted mid-burst clears out_valid without waiting for a clock edge.
